// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: RV32I opcodes, load/store func3 codes, FSM state.
package mem_stage_pkg;

  localparam logic [6:0] OpcR   = 7'b0110011;
  localparam logic [6:0] OpcI1  = 7'b0010011;
  localparam logic [6:0] OpcI2  = 7'b0000011;
  localparam logic [6:0] OpcS   = 7'b0100011;
  localparam logic [6:0] OpcBr  = 7'b1100011;
  localparam logic [6:0] OpcJ   = 7'b1101111;
  localparam logic [6:0] OpcJr  = 7'b1100111;
  localparam logic [6:0] OpcU   = 7'b0110111;
  localparam logic [6:0] OpcUpc = 7'b0010111;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // Legal func3 and natural alignment; stores have no unsigned variants.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3Byte:  ok = 1'b1;
      F3Half:  ok = ~addr_lo[0];
      F3Word:  ok = (addr_lo == 2'b00);
      F3ByteU: ok = ~is_store;
      F3HalfU: ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and memory (slave).
interface mem_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (func3_i)
      F3Byte:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3Half:  data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3ByteU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3HalfU: data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results to WB, runs loads/stores over the dmem bus,
// stalling EX until the memory acknowledges.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] DataStore,
  input  logic [4:0]      rd,
  input  logic [2:0]      func3,
  input  logic [6:0]      opcode,
  output logic            stall,
  mem_stage_if.master     dmem,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mem_err_q, mem_err_d;

  logic            is_load, is_store;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] load_data;

  assign is_load  = (opcode == OpcI2);
  assign is_store = (opcode == OpcS);

  // Store data is replicated across all lanes; byte enables pick the target lane.
  always_comb begin
    case (func3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << result[1:0];
        st_wdata = {(XLEN/8){DataStore[7:0]}};
      end
      2'b01: begin
        st_be    = result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(XLEN/16){DataStore[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = DataStore;
      end
    endcase
  end

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i  (dmem.rdata),
    .addr_lo_i(lo_q),
    .func3_i  (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    lo_d       = lo_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!(is_load || is_store)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (opcode != OpcBr);
            wb_rd_d    = rd;
            wb_data_d  = result;
          end else if (!access_ok(is_store, func3, result[1:0])) begin
            mem_err_d = 1'b1;
          end else begin
            state_d = StWait;
            addr_d  = {result[XLEN-1:2], 2'b00};
            we_d    = is_store;
            be_d    = is_store ? st_be : 4'b1111;
            wdata_d = is_store ? st_wdata : '0;
            rd_d    = rd;
            f3_d    = func3;
            lo_d    = result[1:0];
          end
        end
      end
      StWait: begin
        if (dmem.ack) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_we_d    = ~we_q;
          wb_rd_d    = rd_q;
          wb_data_d  = we_q ? '0 : load_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign stall      = (state_q == StWait);
  assign dmem.req   = (state_q == StWait);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instructions
// checked against an arithmetic reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] result;
  logic [31:0] ds;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [6:0]  opcode;
  logic        stall;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int total;
  int bad;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .result   (result),
    .DataStore(ds),
    .rd       (rd),
    .func3    (func3),
    .opcode   (opcode),
    .stall    (stall),
    .dmem     (dmem),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .mem_err  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned f;
    int unsigned m;
    f = 32'(f3);
    m = a % 4;
    if (f == 0) return 1'b1;
    if (f == 1) return (m % 2) == 0;
    if (f == 2) return m == 0;
    if (!st && f == 4) return 1'b1;
    if (!st && f == 5) return (m % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return ((a % 4) == 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] mem);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = mem >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return mem;
    endcase
  endfunction

  // Issue one instruction, hold garbage on EX while waiting, ack after lat cycles.
  task automatic run_one(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] d, input logic [4:0] r, input int unsigned lat,
                         input logic [31:0] rdat);
    bit is_ld;
    bit is_st;
    is_ld    = (op == OpcI2);
    is_st    = (op == OpcS);
    ex_valid = 1'b1;
    opcode   = op;
    func3    = f3;
    result   = res;
    ds       = d;
    rd       = r;
    tick();
    ex_valid = 1'b0;
    if ((is_ld || is_st) && model_legal(is_st, f3, res)) begin
      check("req_on", 32'(dmem.req), 32'd1);
      check("stall_on", 32'(stall), 32'd1);
      check("addr", dmem.addr, res & 32'hFFFF_FFFC);
      check("be", 32'(dmem.be), is_st ? 32'(model_be(f3, res)) : 32'hF);
      check("we", 32'(dmem.we), 32'(is_st));
      if (is_st) check("wdata", dmem.wdata, model_wdata(f3, d));
      for (int i = 0; i < int'(lat); i++) begin
        ex_valid   = 1'b1;
        opcode     = OpcR;
        result     = $urandom;
        rd         = 5'($urandom_range(0, 31));
        dmem.rdata = $urandom;
        tick();
        check("req_hold", 32'(dmem.req), 32'd1);
        check("addr_hold", dmem.addr, res & 32'hFFFF_FFFC);
        check("wb_idle_in_wait", 32'(wb_valid), 32'd0);
      end
      dmem.ack   = 1'b1;
      dmem.rdata = rdat;
      tick();
      dmem.ack = 1'b0;
      ex_valid = 1'b0;
      check("ack_wb_valid", 32'(wb_valid), 32'd1);
      check("ack_wb_we", 32'(wb_we), 32'(!is_st));
      check("req_off", 32'(dmem.req), 32'd0);
      check("stall_off", 32'(stall), 32'd0);
      if (is_ld) begin
        check("ld_rd", 32'(wb_rd), 32'(r));
        check("ld_data", wb_data, model_load(f3, res, rdat));
      end
    end else if (is_ld || is_st) begin
      check("err_pulse", 32'(mem_err), 32'd1);
      check("err_no_wb", 32'(wb_valid), 32'd0);
      check("err_no_req", 32'(dmem.req), 32'd0);
      check("err_no_stall", 32'(stall), 32'd0);
    end else begin
      check("alu_wb_valid", 32'(wb_valid), 32'd1);
      check("alu_wb_we", 32'(wb_we), 32'(op != OpcBr));
      check("alu_wb_rd", 32'(wb_rd), 32'(r));
      check("alu_wb_data", wb_data, res);
      check("alu_stall", 32'(stall), 32'd0);
      check("alu_no_err", 32'(mem_err), 32'd0);
    end
  endtask

  logic [6:0] ops [12];

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    result     = '0;
    ds         = '0;
    rd         = '0;
    func3      = '0;
    opcode     = '0;
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    ops = '{OpcR, OpcI1, OpcI2, OpcS, OpcBr, OpcJ, OpcJr, OpcU, OpcUpc, OpcI2, OpcS, OpcI2};
    #1 rst = 1'b0;
    #11;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem.req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_addr", dmem.addr, 32'd0);
    check("rst_wdata", dmem.wdata, 32'd0);
    check("rst_be", 32'(dmem.be), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // R-type writeback
    run_one(OpcR, 3'd0, 32'h1234, 32'd0, 5'd3, 0, 32'd0);
    check("r_data_const", wb_data, 32'h1234);
    // SB to 0x102 with a three-cycle memory
    run_one(OpcS, 3'd0, 32'h102, 32'hAB, 5'd0, 3, 32'd0);
    // Sign/zero-extended loads
    run_one(OpcI2, 3'd0, 32'h103, 32'd0, 5'd7, 1, 32'h80FF_0000);
    check("lb_const", wb_data, 32'hFFFF_FF80);
    run_one(OpcI2, 3'd4, 32'h103, 32'd0, 5'd7, 0, 32'h80FF_0000);
    check("lbu_const", wb_data, 32'h0000_0080);
    run_one(OpcI2, 3'd1, 32'h102, 32'd0, 5'd8, 2, 32'h80FF_0000);
    check("lh_const", wb_data, 32'hFFFF_80FF);
    // Misaligned LW: pulse, then next instruction accepted at once
    run_one(OpcI2, 3'd2, 32'h102, 32'd0, 5'd9, 0, 32'd0);
    run_one(OpcU, 3'd0, 32'hCAFE_0000, 32'd0, 5'd10, 0, 32'd0);
    check("err_pulse_clear", 32'(mem_err), 32'd0);
    tick();
    check("wb_single_pulse", 32'(wb_valid), 32'd0);
    // Fastest memory, then back-to-back ALU ops
    run_one(OpcI2, 3'd2, 32'h200, 32'd0, 5'd11, 0, 32'h1357_9BDF);
    run_one(OpcI1, 3'd0, 32'h1, 32'd0, 5'd1, 0, 32'd0);
    run_one(OpcBr, 3'd0, 32'h2, 32'd0, 5'd2, 0, 32'd0);
    run_one(OpcJ, 3'd0, 32'h3, 32'd0, 5'd4, 0, 32'd0);

    // Reset in the middle of a WAIT abandons the access
    ex_valid = 1'b1;
    opcode   = OpcI2;
    func3    = 3'd2;
    result   = 32'h300;
    rd       = 5'd12;
    tick();
    ex_valid = 1'b0;
    check("mid_req_on", 32'(dmem.req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem.req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    #2 rst = 1'b1;
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hDEAD_BEEF;
    tick();
    dmem.ack = 1'b0;
    check("stale_ack_no_wb", 32'(wb_valid), 32'd0);
    check("stale_ack_no_req", 32'(dmem.req), 32'd0);

    for (int n = 0; n < 300; n++) begin
      run_one(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), $urandom, $urandom,
              5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        dmem.ack = 1'($urandom_range(0, 1));
        tick();
        dmem.ack = 1'b0;
        check("gap_no_wb", 32'(wb_valid), 32'd0);
        check("gap_no_err", 32'(mem_err), 32'd0);
        check("gap_no_stall", 32'(stall), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; all data/address ports below are XLEN bits.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  EX presents an instruction this cycle.
REQ-005 result  in  32  ALU result: load/store address or writeback value.
REQ-006 DataStore  in  32  store data (rs2).
REQ-007 rd  in  5; func3  in  3; opcode  in  7  destination register, funct3 and opcode from EX.
REQ-008 stall  out  1  EX shall hold its outputs while high.
REQ-009 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4  data-memory request.
REQ-010 dmem_rdata  in  32; dmem_ack  in  1  memory response; ack completes the request in the cycle it is high.
REQ-011 wb_valid  out  1; wb_we  out  1; wb_rd  out  5; wb_data  out  32  registered WB-stage outputs.
REQ-012 mem_err  out  1  one-cycle pulse for misaligned or illegal-func3 access.

Function
REQ-013 FSM states: IDLE, WAIT; stall = (state==WAIT); dmem_req = (state==WAIT).
REQ-014 IDLE with ex_valid: instruction captured at the clock edge; in WAIT, ex_valid is ignored.
REQ-015 Non-memory opcodes (R, I1, BR, J, JR, U, UPC): wb_valid=1 one cycle after acceptance; wb_data=result; wb_rd=rd; state stays IDLE.
REQ-016 wb_we=1 for R, I1, I2 (loads), J, JR, U, UPC; wb_we=0 for S and BR.
REQ-017 Load (I2) or store (S), aligned: IDLE->WAIT; dmem_addr={result[31:2],2'b00}, dmem_we=1 for S, held constant throughout WAIT.
REQ-018 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{DataStore[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{DataStore[15:0]}}; SW be=1111, wdata=DataStore.
REQ-019 Loads drive be=1111; the lane is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-020 WAIT with dmem_ack=1: data captured; state->IDLE; wb_valid=1 next cycle (stores: wb_valid=1, wb_we=0).
REQ-021 Minimum memory latency: accept T, dmem_req at T+1, ack at T+1 earliest, wb_valid at T+2; the next instruction is accepted at T+2.
REQ-022 Misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]=1) or illegal func3 (load 011/110/111, store >=011): no request, state stays IDLE, wb_valid=0, mem_err=1 one cycle after acceptance.
REQ-023 dmem_ack while IDLE is ignored; wb_valid is a single-cycle pulse per retired instruction.

Reset
REQ-024 rst low immediately forces state=IDLE, dmem_req=0, stall=0, wb_valid=0, wb_we=0, mem_err=0; wb_data, wb_rd, dmem_addr, dmem_wdata, dmem_be=0.
REQ-025 Reset during WAIT abandons the access; a later dmem_ack for it produces no writeback.

Structure
REQ-026 Shared package: opcode constants (I1, I2, S, R, BR, J, JR, U, UPC), load/store func3 codes, FSM state type.
REQ-027 Sub-module load_align (combinational lane select + sign/zero extend) instantiated once.

Verification
REQ-028 R-type, result=32'h1234, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_data=32'h1234, wb_rd=3, stall=0.
REQ-029 SB result=32'h102, DataStore=32'hAB -> dmem_addr=32'h100, be=0100, wdata=32'hABABABAB, we=1; ack after 3 cycles -> wb_valid=1, wb_we=0.
REQ-030 LB addr 32'h103, rdata=32'h80FF_0000 -> wb_data=32'hFFFF_FF80; LBU same -> 32'h0000_0080; LH addr 32'h102 -> 32'hFFFF_80FF.
REQ-031 LW addr 32'h102 -> mem_err pulse, dmem_req never asserted, wb_valid=0, next instruction accepted the following cycle.
REQ-032 Ack in the first WAIT cycle -> stall high exactly 1 cycle, wb_valid at T+2; back-to-back ALU ops retire one per cycle.
REQ-033 rst low mid-WAIT, then ack after release -> dmem_req=0 immediately, no wb_valid.
